// File: rtl/bram_pixel_reader.sv
// Streams a contiguous range of 32-bit BRAM words out as RGB565 pixels, two per word.
// Define BRAM_PIXEL_READER_HI_FIRST_EN to emit [31:16] before [15:0] within each word.
module bram_pixel_reader #(
   parameter int ADDR_WIDTH = 14,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clka,
   input  logic                  rstn_a,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  word_count,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [3:0]            ram_wea,
   output logic [31:0]           ram_dina,
   input  logic [31:0]           ram_douta,
   output logic [15:0]           pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t               state;
   logic                 iss_q, dv_q;
   logic                 half_vld, pre_vld;
   logic [15:0]          half_data;
   logic [31:0]          pre_w;
   logic [LEN_WIDTH-1:0] rd_left;

   logic                 take, arr, nv, nh, np, issue;
   logic [15:0]          nd, nhd;
   logic [31:0]          npw;
   logic [2:0]           occ;

   function automatic logic [15:0] first_px(input logic [31:0] w);
`ifdef BRAM_PIXEL_READER_HI_FIRST_EN
      return w[31:16];
`else
      return w[15:0];
`endif
   endfunction

   function automatic logic [15:0] second_px(input logic [31:0] w);
`ifdef BRAM_PIXEL_READER_HI_FIRST_EN
      return w[15:0];
`else
      return w[31:16];
`endif
   endfunction

   assign ram_wea  = 4'b0000;
   assign ram_dina = '0;

   // Pixels drain oldest-first: pending half, then prefetch word, then the word
   // arriving on ram_douta (bypassed straight to the output when nothing is queued).
   always_comb begin
      take = !pix_valid || pix_ready;
      nv   = pix_valid && !pix_ready;
      nd   = pix_data;
      nh   = half_vld;
      nhd  = half_data;
      np   = pre_vld;
      npw  = pre_w;
      arr  = dv_q;
      if (take) begin
         if (half_vld) begin
            nv = 1'b1;
            nd = half_data;
            nh = 1'b0;
         end else if (pre_vld) begin
            nv  = 1'b1;
            nd  = first_px(pre_w);
            nh  = 1'b1;
            nhd = second_px(pre_w);
            np  = 1'b0;
         end else if (dv_q) begin
            nv  = 1'b1;
            nd  = first_px(ram_douta);
            nh  = 1'b1;
            nhd = second_px(ram_douta);
            arr = 1'b0;
         end
      end
      if (arr) begin
         np  = 1'b1;
         npw = ram_douta;
      end
   end

   // Pixels held after this edge plus the word already in flight; a new read is
   // only issued when its two pixels are sure to fit even if the sink stalls.
   assign occ   = 3'(nv) + 3'(nh) + {1'b0, np, 1'b0} + {1'b0, iss_q, 1'b0};
   assign issue = (state == RUN) && (occ <= 3'd2);

   always_ff @(posedge clka or negedge rstn_a) begin
      if (!rstn_a) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         ram_addr  <= '0;
         iss_q     <= 1'b0;
         dv_q      <= 1'b0;
         rd_left   <= '0;
         pix_valid <= 1'b0;
         pix_data  <= '0;
         half_vld  <= 1'b0;
         half_data <= '0;
         pre_vld   <= 1'b0;
         pre_w     <= '0;
      end else if (abort) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         iss_q     <= 1'b0;
         dv_q      <= 1'b0;
         pix_valid <= 1'b0;
         half_vld  <= 1'b0;
         pre_vld   <= 1'b0;
      end else begin
         pix_valid <= nv;
         pix_data  <= nd;
         half_vld  <= nh;
         half_data <= nhd;
         pre_vld   <= np;
         pre_w     <= npw;
         dv_q      <= iss_q;
         iss_q     <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (word_count == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state    <= (word_count == LEN_WIDTH'(1)) ? FLUSH : RUN;
                  busy     <= 1'b1;
                  ram_addr <= base_addr;
                  iss_q    <= 1'b1;
                  rd_left  <= word_count - LEN_WIDTH'(1);
               end
            end
            RUN: if (issue) begin
               ram_addr <= ram_addr + ADDR_WIDTH'(1);
               iss_q    <= 1'b1;
               rd_left  <= rd_left - LEN_WIDTH'(1);
               if (rd_left == LEN_WIDTH'(1)) state <= FLUSH;
            end
            FLUSH: if (!iss_q && !nv && !nh && !np) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/bram_pixel_reader.md
Name: bram_pixel_reader

Overview:
- Read-side initiator for the 32-bit Block RAM port, which has byte-write enables and 1-cycle registered read data.
- Streams a contiguous range of RAM words out as RGB565 pixels over a valid/ready interface to the LCD pixel path.
- Each RAM word carries two pixels.
- Hides the RAM read latency so that, with the sink always ready, it sustains one pixel per clock.

Parameters:
- ADDR_WIDTH, 14, RAM word-address width; must match the RAM instance.
- LEN_WIDTH, 16, width of the word-count request field.

Ports:
- clka  input  1  clock; shared with the RAM port.
- rstn_a  input  1  asynchronous active-low reset.
- start  input  1  1-cycle request pulse; sampled only in IDLE.
- abort  input  1  synchronous cancel of the current transfer.
- base_addr  input  ADDR_WIDTH  first word address; captured on an accepted start.
- word_count  input  LEN_WIDTH  number of words to read; captured on an accepted start.
- busy  output  1  high from the accepted start until done or abort.
- done  output  1  1-cycle pulse after the last pixel is accepted.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_wea  output  4  tied 4'b0000.
- ram_dina  output  32  tied 0.
- ram_douta  input  32  RAM read data; valid 1 cycle after ram_addr.
- pix_data  output  16  pixel.
- pix_valid  output  1  pixel valid.
- pix_ready  input  1  sink ready.

Behaviour:
- Reset (async, rstn_a=0): all outputs 0; FSM in IDLE; buffers empty.
- FSM states:
  - IDLE: wait for start.
  - RUN: issue reads and emit pixels.
  - FLUSH: last read issued; drain the remaining buffered pixels.
  - DONE: assert done for 1 cycle, then go to IDLE.
- start handling:
  - start in IDLE with word_count=0: go directly to DONE. No RAM reads, pix_valid stays 0; done pulses the cycle after start.
  - start in any non-IDLE state: ignored.
- Read issue:
  - First ram_addr=base_addr is driven the cycle after start.
  - First pix_valid is asserted 2 cycles after the ram_addr cycle.
  - Addresses increment by 1 per issued read and wrap modulo 2^ADDR_WIDTH; 3FFF is followed by 0000.
- Buffering:
  - Word buffer is 2 entries: the current word plus a prefetch slot.
  - A read is issued only if its returning data is guaranteed a free slot. Returning data is never dropped and the RAM is never stalled.
  - Reads issued = word_count exactly; no over-fetch.
- Pixel order: low half ([15:0]) first, then high half ([31:16]).
  - Each word produces exactly 2 pixels, for 2×word_count pixels total.
- Handshake:
  - Transfer occurs when pix_valid && pix_ready.
  - pix_data and pix_valid are registered and stay stable while pix_valid=1 && pix_ready=0.
  - pix_valid never drops without a transfer, except on abort or reset.
- Throughput: with pix_ready held at 1, exactly one pixel per cycle after the first.
- done rules:
  - done pulses the cycle after the final pixel transfer; busy falls in the same cycle done rises.
  - A new start is accepted in the cycle after done.
- abort:
  - Takes effect next cycle: IDLE, busy=0, pix_valid=0, buffers cleared, no done.
  - Read data still in flight is discarded.
  - abort in IDLE has no effect.
  - If abort and start arrive in the same cycle, abort wins.
- Reset mid-transfer: immediate return to the reset state; no done.

Optional Feature:
- Macro: BRAM_PIXEL_READER_HI_FIRST_EN.
- Defined: pixel order per word is [31:16] first, then [15:0].
- Undefined: [15:0] first, as specified above.
- Timing and counts are identical in both builds.

Test Plan:
- mem[0x10]=0xBBBB_AAAA, mem[0x11]=0xDDDD_CCCC; start with base=0x10, count=2; pix_ready=1 -> pix_data sequence AAAA, BBBB, CCCC, DDDD on 4 consecutive cycles; done 1 cycle after DDDD; ram_wea=0 throughout.
- Wrap: base=0x3FFF, count=2, ADDR_WIDTH=14 -> ram_addr sequence 3FFF then 0000; 4 pixels emitted.
- Backpressure: count=8 with a random pix_ready pattern (~50%) -> exactly 16 pixels in address order; pix_data held stable whenever stalled; no pixel lost or duplicated.
- count=0 -> done 1 cycle after start; pix_valid never asserted; no ram_addr change.
- Abort after 3 pixels of a count=4 transfer -> pix_valid=0 and busy=0 next cycle; no done. A subsequent start with base=0x20, count=1 emits only mem[0x20] data.
- Reset mid-transfer (rstn_a low for 1 cycle) -> outputs 0 asynchronously. With BRAM_PIXEL_READER_HI_FIRST_EN defined, rerun the first case -> BBBB, AAAA, DDDD, CCCC.
